// File: rtl/gat_pkg.sv
// Shared GAT types and sizes: WH BRAM word layout, score widths, scorer FSM states.
// Purely declarative; no latency or flow control of its own.
package gat_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int W_NUM_OF_COLS  = 16;
    localparam int NUM_OF_NODES   = 168;
    localparam int WH_DEPTH       = 242101;
    localparam int NUM_NODE_WIDTH = $clog2(NUM_OF_NODES) + 1;
    localparam int WH_ADDR_W      = $clog2(WH_DEPTH);
    localparam int PROD_WIDTH     = 2 * DATA_WIDTH;
    localparam int SCORE_WIDTH    = 2 * DATA_WIDTH + $clog2(W_NUM_OF_COLS) + 1;
    localparam int DOT_WIDTH      = SCORE_WIDTH - 1;
    localparam int LRELU_SHIFT    = 3;

    // result[W_NUM_OF_COLS-1] is result_1 (MSB end of the word)
    typedef struct packed {
        logic [W_NUM_OF_COLS-1:0][DATA_WIDTH-1:0] result;
        logic [NUM_NODE_WIDTH-1:0]                num_of_nodes;
        logic                                     source_node_flag;
    } WH_t;

    localparam int WH_WIDTH = $bits(WH_t);

    typedef struct packed {
        logic [NUM_NODE_WIDTH-1:0] num_of_nodes;
        logic                      source_node_flag;
    } node_info_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/attn_dot_tree.sv
// Signed 16-lane dot product: registered products (S1) then registered reduction (S2), 2 cycles.
// en low freezes both stages so the caller can stall the whole pipeline.
module attn_dot_tree
    import gat_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] wh [W_NUM_OF_COLS],
    input  logic signed [DATA_WIDTH-1:0] a  [W_NUM_OF_COLS],
    output logic signed [DOT_WIDTH-1:0]  dot
);

    logic signed [PROD_WIDTH-1:0] prod [W_NUM_OF_COLS];
    logic signed [DOT_WIDTH-1:0]  sum_c;

    always_comb begin
        sum_c = '0;
        for (int k = 0; k < W_NUM_OF_COLS; k++) begin
            sum_c = sum_c + DOT_WIDTH'(prod[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < W_NUM_OF_COLS; k++) begin
                prod[k] <= '0;
            end
            dot <= '0;
        end else if (en) begin
            for (int k = 0; k < W_NUM_OF_COLS; k++) begin
                prod[k] <= PROD_WIDTH'(wh[k]) * PROD_WIDTH'(a[k]);
            end
            dot <= sum_c;
        end
    end

endmodule

// File: rtl/wh_attn_score.sv
// Per-row attention scores e = a_src.Wh_src + a_nbr.Wh_j from WH BRAM rows; LEAKY_RELU_EN adds LeakyReLU.
// 4 cycles addrb->score_valid_o; score_valid_o && !score_ready_i freezes the read port and every stage.
module wh_attn_score
    import gat_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          score_valid_i,
    input  logic [WH_ADDR_W:0]            wh_avail_i,
    input  logic                          wh_done_i,
    input  logic [WH_WIDTH-1:0]           WH_BRAM_dout,
    output logic [WH_ADDR_W-1:0]          WH_BRAM_addrb,
    input  logic signed [DATA_WIDTH-1:0]  a_src_i [W_NUM_OF_COLS],
    input  logic signed [DATA_WIDTH-1:0]  a_nbr_i [W_NUM_OF_COLS],
    output logic signed [SCORE_WIDTH-1:0] score_o,
    output logic                          score_valid_o,
    input  logic                          score_ready_i,
    output logic                          score_last_o,
    output logic                          score_first_o,
    output logic                          done_o,
    output logic                          err_o
);

    state_t                       state, state_nxt;
    logic [WH_ADDR_W:0]           rd_addr;
    logic                         stall, en, issue, pipe_empty;
    logic                         rd_pend, v0, v1, v2;
    logic                         hold_vld;
    WH_t                          row_hold, row_sel;
    node_info_t                   info1, info2;
    logic signed [DATA_WIDTH-1:0] wh_lane [W_NUM_OF_COLS];
    logic signed [DOT_WIDTH-1:0]  dot_src, dot_nbr;

    logic                         sub_open, open_nxt;
    logic [NUM_NODE_WIDTH-1:0]    cnt, cnt_nxt, n_q, n_nxt;
    logic signed [DOT_WIDTH-1:0]  src_dot_q, src_nxt, base;
    logic signed [SCORE_WIDTH-1:0] e_sum, act;
    logic                         first_c, last_c, err_nxt;

    assign stall      = score_valid_o && !score_ready_i;
    assign en         = !stall;
    assign issue      = (state == ST_FETCH) && (rd_addr < wh_avail_i) && en;
    assign pipe_empty = !(rd_pend || v0 || v1 || v2 || score_valid_o);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (score_valid_i) state_nxt = ST_FETCH;
            ST_FETCH: if (wh_done_i && rd_addr == wh_avail_i) state_nxt = ST_DRAIN;
            ST_DRAIN: if (pipe_empty) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        done_o = (state == ST_DONE);
    end

    // addrb only moves on an issue, so it always names the row in flight to dout
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr       <= '0;
            WH_BRAM_addrb <= '0;
            rd_pend       <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                rd_addr <= '0;
            end else if (issue) begin
                rd_addr       <= rd_addr + (WH_ADDR_W+1)'(1);
                WH_BRAM_addrb <= rd_addr[WH_ADDR_W-1:0];
            end
            if (en) rd_pend <= issue;
        end
    end

    // dout may already belong to a newer address one cycle into a stall; keep a copy of the S0 row
    assign row_sel = hold_vld ? row_hold : WH_t'(WH_BRAM_dout);

    always_comb begin
        for (int k = 0; k < W_NUM_OF_COLS; k++) begin
            wh_lane[k] = row_sel.result[W_NUM_OF_COLS-1-k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld <= 1'b0;
            row_hold <= '0;
            v0       <= 1'b0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            info1    <= '0;
            info2    <= '0;
        end else begin
            if (stall && v0 && !hold_vld) begin
                hold_vld <= 1'b1;
                row_hold <= WH_t'(WH_BRAM_dout);
            end else if (en) begin
                hold_vld <= 1'b0;
            end
            if (en) begin
                v0    <= rd_pend;
                v1    <= v0;
                v2    <= v1;
                info1 <= '{num_of_nodes: row_sel.num_of_nodes, source_node_flag: row_sel.source_node_flag};
                info2 <= info1;
            end
        end
    end

    attn_dot_tree u_dot_src (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .wh  (wh_lane),
        .a   (a_src_i),
        .dot (dot_src)
    );

    attn_dot_tree u_dot_nbr (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .wh  (wh_lane),
        .a   (a_nbr_i),
        .dot (dot_nbr)
    );

    // S3 framing: a source row opens a subgraph and scores against its own dot_src
    always_comb begin
        base     = src_dot_q;
        src_nxt  = src_dot_q;
        n_nxt    = n_q;
        cnt_nxt  = cnt;
        open_nxt = sub_open;
        first_c  = 1'b0;
        last_c   = 1'b0;
        err_nxt  = err_o;
        if (info2.source_node_flag) begin
            err_nxt  = err_o || sub_open;
            base     = dot_src;
            src_nxt  = dot_src;
            n_nxt    = info2.num_of_nodes;
            first_c  = 1'b1;
            last_c   = (info2.num_of_nodes == NUM_NODE_WIDTH'(1));
            cnt_nxt  = NUM_NODE_WIDTH'(1);
            open_nxt = !last_c;
        end else if (sub_open) begin
            last_c   = (cnt == n_q - NUM_NODE_WIDTH'(1));
            cnt_nxt  = cnt + NUM_NODE_WIDTH'(1);
            open_nxt = !last_c;
        end else begin
            err_nxt  = 1'b1;
            base     = '0;
        end
        e_sum = SCORE_WIDTH'(base) + SCORE_WIDTH'(dot_nbr);
`ifdef LEAKY_RELU_EN
        act = e_sum[SCORE_WIDTH-1] ? (e_sum >>> LRELU_SHIFT) : e_sum;
`else
        act = e_sum;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            score_o       <= '0;
            score_valid_o <= 1'b0;
            score_first_o <= 1'b0;
            score_last_o  <= 1'b0;
            err_o         <= 1'b0;
            sub_open      <= 1'b0;
            cnt           <= '0;
            n_q           <= '0;
            src_dot_q     <= '0;
        end else if (en) begin
            score_valid_o <= v2;
            if (v2) begin
                score_o       <= act;
                score_first_o <= first_c;
                score_last_o  <= last_c;
                err_o         <= err_nxt;
                sub_open      <= open_nxt;
                cnt           <= cnt_nxt;
                n_q           <= n_nxt;
                src_dot_q     <= src_nxt;
            end
        end
    end

endmodule

// File: tb/tb_wh_attn_score.sv
// Randomised scoreboard bench for wh_attn_score: a row-level reference model queues expected scores, a negedge monitor checks them.
module tb_wh_attn_score;
    import gat_pkg::*;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          score_valid_i;
    logic [WH_ADDR_W:0]            wh_avail_i;
    logic                          wh_done_i;
    logic [WH_WIDTH-1:0]           WH_BRAM_dout;
    logic [WH_ADDR_W-1:0]          WH_BRAM_addrb;
    logic signed [DATA_WIDTH-1:0]  a_src [W_NUM_OF_COLS];
    logic signed [DATA_WIDTH-1:0]  a_nbr [W_NUM_OF_COLS];
    logic signed [SCORE_WIDTH-1:0] score_o;
    logic                          score_valid_o, score_ready_i, score_last_o, score_first_o, done_o, err_o;

    wh_attn_score dut (
        .clk           (clk),
        .rst           (rst),
        .score_valid_i (score_valid_i),
        .wh_avail_i    (wh_avail_i),
        .wh_done_i     (wh_done_i),
        .WH_BRAM_dout  (WH_BRAM_dout),
        .WH_BRAM_addrb (WH_BRAM_addrb),
        .a_src_i       (a_src),
        .a_nbr_i       (a_nbr),
        .score_o       (score_o),
        .score_valid_o (score_valid_o),
        .score_ready_i (score_ready_i),
        .score_last_o  (score_last_o),
        .score_first_o (score_first_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    logic [WH_WIDTH-1:0] mem [256];
    always @(posedge clk) WH_BRAM_dout <= (WH_BRAM_addrb < 256) ? mem[WH_BRAM_addrb[7:0]] : '0;

    typedef struct { int score; bit first; bit last; } exp_t;
    exp_t exp_q [$];
    exp_t mon_e;

    int  checks = 0, errors = 0;
    int  done_cnt = 0, pop_cnt = 0;
    bit  prev_stall = 0, chk_addr = 0;
    int  held_score;
    bit  held_first, held_last;
    logic [WH_ADDR_W-1:0] prev_addrb = '0;

    // row stimulus and model state
    int  row_wh [64][16];
    bit  row_flag [64];
    int  row_n [64];
    bit  m_open, exp_err;
    int  m_src, m_n, m_cnt;

    function automatic int dot(input int r, input bit nbr);
        int s = 0;
        for (int k = 0; k < W_NUM_OF_COLS; k++)
            s += row_wh[r][k] * (nbr ? int'(a_nbr[k]) : int'(a_src[k]));
        return s;
    endfunction

    function automatic logic [WH_WIDTH-1:0] build(input int r);
        logic [WH_WIDTH-1:0] w = '0;
        for (int k = 0; k < W_NUM_OF_COLS; k++)
            w[WH_WIDTH-1-DATA_WIDTH*k -: DATA_WIDTH] = DATA_WIDTH'(row_wh[r][k]);
        w[NUM_NODE_WIDTH:1] = NUM_NODE_WIDTH'(row_n[r]);
        w[0] = row_flag[r];
        return w;
    endfunction

    task automatic push_expected(input int nrows);
        exp_t x;
        int e;
        for (int r = 0; r < nrows; r++) begin
            x.first = 0;
            x.last  = 0;
            if (row_flag[r]) begin
                if (m_open) exp_err = 1;
                m_src = dot(r, 0); m_n = row_n[r]; m_cnt = 0; m_open = 1;
                x.first = 1;
            end
            if (m_open) begin
                e = m_src + dot(r, 1);
                x.last = (m_cnt == m_n - 1);
                m_cnt++;
                if (x.last) m_open = 0;
            end else begin
                exp_err = 1;
                e = dot(r, 1);
            end
`ifdef LEAKY_RELU_EN
            if (e < 0) e = e >>> 3;
`endif
            x.score = e;
            exp_q.push_back(x);
        end
    endtask

    task automatic load(input int nrows);
        for (int r = 0; r < nrows; r++) mem[r] = build(r);
        push_expected(nrows);
    endtask

    task automatic gen_random(input int nrows);
        int r = 0, n;
        while (r < nrows) begin
            n = int'($urandom_range(1, 4));
            if (n > nrows - r) n = nrows - r;
            for (int j = 0; j < n; j++) begin
                row_flag[r+j] = (j == 0);
                row_n[r+j]    = n;
                for (int k = 0; k < W_NUM_OF_COLS; k++) row_wh[r+j][k] = int'($urandom_range(0, 255)) - 128;
            end
            r += n;
        end
    endtask

    task automatic rand_weights();
        for (int k = 0; k < W_NUM_OF_COLS; k++) begin
            a_src[k] = DATA_WIDTH'($urandom_range(0, 255));
            a_nbr[k] = DATA_WIDTH'($urandom_range(0, 255));
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic do_reset();
        rst = 1; score_valid_i = 0; score_ready_i = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_score", int'(score_o), 0);
        check("rst_valid", int'(score_valid_o), 0);
        check("rst_first", int'(score_first_o), 0);
        check("rst_last", int'(score_last_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_err", int'(err_o), 0);
        check("rst_addrb", int'(WH_BRAM_addrb), 0);
        rst = 0;
        exp_q.delete();
        m_open = 0; exp_err = 0;
    endtask

    // rmode: 0 always ready, 1 toggling, 2 random
    task automatic run(input string name, input int nrows, input bit throttle, input int rmode);
        int avail, cyc = 0, d0 = done_cnt;
        avail = throttle ? 0 : nrows;
        wh_avail_i = (WH_ADDR_W+1)'(avail);
        wh_done_i = !throttle;
        chk_addr = throttle;
        score_valid_i = 1;
        while (done_cnt == d0 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (throttle && cyc % 5 == 0 && avail < nrows) begin
                avail++;
                wh_avail_i = (WH_ADDR_W+1)'(avail);
                if (avail == nrows) wh_done_i = 1;
            end
            case (rmode)
                1:       score_ready_i = !score_ready_i;
                2:       score_ready_i = 1'($urandom_range(0, 1));
                default: score_ready_i = 1;
            endcase
        end
        score_valid_i = 0;
        score_ready_i = 1;
        chk_addr = 0;
        check({name, "_done_seen"}, int'(done_cnt != d0), 1);
        repeat (6) @(posedge clk);
        #1;
        check({name, "_left_in_queue"}, exp_q.size(), 0);
        check({name, "_done_pulses"}, done_cnt - d0, 1);
        check({name, "_err"}, int'(err_o), int'(exp_err));
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!score_valid_o || int'(score_o) != held_score || score_first_o != held_first || score_last_o != held_last) begin
                    errors++;
                    $display("FAIL hold_stable: got v=%0b s=%0d f=%0b l=%0b, required v=1 s=%0d f=%0b l=%0b",
                             score_valid_o, score_o, score_first_o, score_last_o, held_score, held_first, held_last);
                end
            end
            if (score_valid_o && score_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_score: got %0d with nothing expected", score_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (int'(score_o) != mon_e.score || score_first_o != mon_e.first || score_last_o != mon_e.last) begin
                        errors++;
                        $display("FAIL score #%0d: got s=%0d f=%0b l=%0b, required s=%0d f=%0b l=%0b",
                                 pop_cnt, score_o, score_first_o, score_last_o, mon_e.score, mon_e.first, mon_e.last);
                    end
                end
                pop_cnt++;
            end
            prev_stall = score_valid_o && !score_ready_i;
            held_score = int'(score_o);
            held_first = score_first_o;
            held_last  = score_last_o;
            if (done_o) done_cnt++;
            if (chk_addr && WH_BRAM_addrb != prev_addrb) begin
                checks++;
                if (WH_BRAM_addrb >= wh_avail_i) begin
                    errors++;
                    $display("FAIL addr_bound: got addrb %0d, required below %0d", WH_BRAM_addrb, wh_avail_i);
                end
            end
            prev_addrb = WH_BRAM_addrb;
        end
    end

    initial begin
        int cyc;
        rst = 1; score_valid_i = 0; wh_avail_i = '0; wh_done_i = 0; score_ready_i = 1;
        for (int k = 0; k < W_NUM_OF_COLS; k++) begin a_src[k] = '0; a_nbr[k] = '0; end
        for (int i = 0; i < 256; i++) mem[i] = '0;
        do_reset();

        // single subgraph of three, all-ones rows
        for (int r = 0; r < 3; r++) begin
            row_flag[r] = (r == 0); row_n[r] = 3;
            for (int k = 0; k < W_NUM_OF_COLS; k++) row_wh[r][k] = 1;
        end
        for (int k = 0; k < W_NUM_OF_COLS; k++) begin a_src[k] = 1; a_nbr[k] = 2; end
        load(3);
        run("n3", 3, 0, 0);

        // negative sum, single-node subgraph
        row_flag[0] = 1; row_n[0] = 1;
        for (int k = 0; k < W_NUM_OF_COLS; k++) begin row_wh[0][k] = -1; a_src[k] = 1; a_nbr[k] = 1; end
        load(1);
        run("neg", 1, 0, 0);

        // backpressure: ready toggles every cycle
        rand_weights(); gen_random(10); load(10);
        run("bp", 10, 0, 1);

        // throttled availability
        rand_weights(); gen_random(8); load(8);
        run("thr", 8, 1, 2);

        // framing errors: orphan row, then a source row while a subgraph is still open
        rand_weights(); gen_random(4);
        row_flag[0] = 0; row_n[0] = 2;
        row_flag[1] = 1; row_n[1] = 2;
        row_flag[2] = 1; row_n[2] = 2;
        row_flag[3] = 0; row_n[3] = 2;
        load(4);
        run("ferr", 4, 0, 0);
        gen_random(3); load(3);
        run("sticky", 3, 0, 2);

        // reset after two of five outputs, then rerun
        do_reset();
        rand_weights();
        for (int r = 0; r < 5; r++) begin
            row_flag[r] = (r == 0); row_n[r] = 5;
            for (int k = 0; k < W_NUM_OF_COLS; k++) row_wh[r][k] = int'($urandom_range(0, 255)) - 128;
        end
        load(5);
        pop_cnt = 0; cyc = 0;
        wh_avail_i = (WH_ADDR_W+1)'(5); wh_done_i = 1; score_valid_i = 1;
        while (pop_cnt < 2 && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
            score_ready_i = 1'($urandom_range(0, 1));
        end
        check("midrst_two_out", int'(pop_cnt >= 2), 1);
        do_reset();
        load(5);
        run("rerun", 5, 0, 0);

        // random runs
        for (int t = 0; t < 4; t++) begin
            int n = int'($urandom_range(3, 30));
            rand_weights(); gen_random(n); load(n);
            run("rand", n, 1'($urandom_range(0, 1)), 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wh_attn_score.md
Name: wh_attn_score

Overview:
- Downstream neighbour of the sparse SpMM stage. Reads packed WH rows from the WH BRAM port B as they are written, and computes per-row attention dot products against two attention vectors, a_src and a_nbr.
- Emits one raw attention score per (source, neighbour) entry: e = LeakyReLU(a_src·Wh_src + a_nbr·Wh_j).
- Feeds the softmax/coefficient stage through a valid/ready stream carrying subgraph framing.

Parameters:
- DATA_WIDTH, 8: signed width of each WH element and attention weight.
- W_NUM_OF_COLS, 16: WH row length (number of dot-product lanes).
- NUM_OF_NODES, 168: maximum nodes per subgraph.
- WH_DEPTH, 242101: WH BRAM depth.
- NUM_NODE_WIDTH, $clog2(NUM_OF_NODES)+1: width of the node-count field.
- WH_WIDTH, DATA_WIDTH*W_NUM_OF_COLS+NUM_NODE_WIDTH+1: WH BRAM word width.
- WH_ADDR_W, $clog2(WH_DEPTH): WH BRAM address width.
- SCORE_WIDTH, 2*DATA_WIDTH+$clog2(W_NUM_OF_COLS)+1: output score width.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- score_valid_i, in, 1: start/enable level; must stay high for the whole run.
- wh_avail_i, in, WH_ADDR_W+1: count of WH rows already written by SpMM.
- wh_done_i, in, 1: SpMM has written its final row.
- WH_BRAM_dout, in, WH_WIDTH: read data. Layout is {result_1..result_16 (MSB first), num_of_nodes, source_node_flag}. Latency is 1 cycle.
- WH_BRAM_addrb, out, WH_ADDR_W: read address.
- a_src_i, in, DATA_WIDTH x W_NUM_OF_COLS (unpacked): source attention vector.
- a_nbr_i, in, DATA_WIDTH x W_NUM_OF_COLS (unpacked): neighbour attention vector.
- score_o, out, SCORE_WIDTH: signed attention score.
- score_valid_o, out, 1: score_o is valid.
- score_ready_i, in, 1: downstream accepts the score.
- score_last_o, out, 1: current score is the last entry of its subgraph.
- score_first_o, out, 1: current score is the source (self) entry.
- done_o, out, 1: one-cycle pulse when the run completes.
- err_o, out, 1: sticky framing error.

Behaviour:
- FSM states:
  - IDLE → FETCH when score_valid_i is high.
  - FETCH → DRAIN when wh_done_i=1 and rd_addr==wh_avail_i.
  - DRAIN → DONE when the pipeline is empty.
  - DONE pulses done_o for one cycle, then returns to IDLE. rd_addr clears on IDLE entry.
- Read issue in FETCH: a read is issued when rd_addr < wh_avail_i and the pipeline is not stalled. WH_BRAM_addrb = rd_addr. rd_addr increments on each issue and never passes wh_avail_i.
- Stall condition: stall = score_valid_o && !score_ready_i.
  - During a stall, addrb and all pipeline registers hold, so BRAM dout stays stable.
  - No data is dropped or duplicated.
- Pipeline: 4 cycles from address issue to score_valid_o when there is no stall.
  - S0: BRAM read.
  - S1: 2×16 signed products, each 2*DATA_WIDTH bits, registered.
  - S2: two adder trees, registered, producing dot_src and dot_nbr (SCORE_WIDTH-1 bits each, sign-extended).
  - S3: combine, activate, register the output.
- Framing in S3:
  - Row with source_node_flag=1 opens a subgraph:
    - latch src_dot=dot_src and n=num_of_nodes, reset cnt=0;
    - the score uses this row's own dot_src (bypass);
    - score_first_o=1.
  - Every row (source included) outputs e = src_dot + dot_nbr, then increments cnt.
  - score_last_o=1 when cnt==n-1. n=1 means first and last on the same row.
- Errors:
  - Non-source row with no open subgraph: set err_o, still emit the score using src_dot=0.
  - Source row while the previous subgraph is still open: set err_o, open the new subgraph.
- Arithmetic: all signed, no saturation; SCORE_WIDTH cannot overflow for 16 lanes.
- Reset values: addrb=0, score_o=0, score_valid_o=0, score_first_o=0, score_last_o=0, done_o=0, err_o=0, FSM=IDLE, all pipeline valids=0.
- Reset mid-run flushes everything in the next cycle.
- score_valid_i falling mid-run: the block finishes its current run anyway. It is sampled only in IDLE.

Optional Feature:
- Macro LEAKY_RELU_EN.
- Defined: S3 applies LeakyReLU. Negative e becomes e >>> 3 (arithmetic shift, slope 1/8); non-negative e passes through.
- Undefined: score_o is the raw sum e. Latency is unchanged.

Decomposition:
- Shared package gat_pkg holds:
  - the WH_t packed struct and the node_info field widths;
  - SCORE_WIDTH, the LeakyReLU shift constant (3), and the FSM state enum.
- One sub-module, attn_dot_tree: 16 signed multipliers plus a registered adder tree (stages S1–S2), instantiated twice.

Test Plan:
- Single subgraph, n=3: flags 1,0,0; all WH=1, a_src=all 1, a_nbr=all 2 → three scores of 48. First is asserted on score 0, last on score 2, done_o pulses once.
- Negative sum with LEAKY_RELU_EN: WH=-1, a_src=1, a_nbr=1, n=1 → e=-32, score_o=-4, first=last=1. With the macro undefined, score_o=-32.
- Backpressure: score_ready_i toggles 1/0 every cycle over 10 rows → exactly 10 scores in order, and the output is held stable while valid and not ready.
- Throttled availability: wh_avail_i steps +1 every 5 cycles → addrb never reaches wh_avail_i; completes after wh_done_i.
- Framing error: a non-source row first, then a source row with n=2 followed by another source row → err_o sets and stays high until rst.
- Reset mid-run after 2 of 5 outputs → all outputs 0 the next cycle; a rerun from address 0 produces all 5 scores correctly.
